// File: rtl/turret_aim_ctrl.sv
// Turret elevation controller: keycode -> registered angle index / one-hot select,
// with press-edge stepping, frame-paced auto-repeat, saturate/wrap and recenter.
module turret_aim_ctrl #(
  parameter int          NUM_STEPS    = 9,
  parameter int          HOME_IDX     = 4,
  parameter logic [7:0]  KEY_UP       = 8'h1A,
  parameter logic [7:0]  KEY_DOWN     = 8'h16,
  parameter int          REPEAT_DELAY = 3,
  parameter int          REPEAT_RATE  = 2,
  parameter bit          WRAP         = 1'b0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [7:0]                   keycode,
  input  logic                         frame_tick,
  input  logic                         recenter,
  output logic [$clog2(NUM_STEPS)-1:0] angle_idx,
  output logic [NUM_STEPS-1:0]         angle_onehot,
  output logic                         at_min,
  output logic                         at_max,
  output logic                         moved
);
  localparam int IW   = $clog2(NUM_STEPS);
  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [IW-1:0]        LAST    = IW'(NUM_STEPS - 1);
  localparam logic [IW-1:0]        HOME    = IW'(HOME_IDX);
  localparam logic [NUM_STEPS-1:0] ONE     = NUM_STEPS'(1);
  localparam logic [CW-1:0]        DLY_END = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0]        RPT_END = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_LOCKOUT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          dir_up;
  logic          up, dn, key, dir_chg;
  logic          step, step_up, cnt_clr, cnt_inc;
  logic [IW-1:0] idx_nxt;

  assign up  = (keycode == KEY_UP);
  assign dn  = (keycode == KEY_DOWN);
  assign key = up | dn;
  // dir_up remembers the direction of the last issued step, so a swap of keys
  // between consecutive cycles is seen as a fresh press.
  assign dir_chg = (up && !dir_up) || (dn && dir_up);

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (key) state_nxt = S_DELAY;
      S_DELAY: begin
        if (!key)                              state_nxt = S_IDLE;
        else if (dir_chg)                      state_nxt = S_DELAY;
        else if (frame_tick && cnt == DLY_END) state_nxt = S_REPEAT;
      end
      S_REPEAT: begin
        if (!key)         state_nxt = S_IDLE;
        else if (dir_chg) state_nxt = S_DELAY;
      end
      S_LOCKOUT: if (!key) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (recenter) state_nxt = key ? S_LOCKOUT : S_IDLE;
  end

  always_comb begin
    step    = 1'b0;
    step_up = up;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      S_IDLE: if (key) begin step = 1'b1; cnt_clr = 1'b1; end
      S_DELAY, S_REPEAT: begin
        if (!key) cnt_clr = 1'b1;
        else if (dir_chg) begin
          step    = 1'b1;
          cnt_clr = 1'b1;
        end else if (frame_tick) begin
          if (cnt == ((state == S_DELAY) ? DLY_END : RPT_END)) begin
            step    = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Recenter overrides any step decided in the same cycle.
  always_comb begin
    idx_nxt = angle_idx;
    if (recenter) idx_nxt = HOME;
    else if (step) begin
      if (step_up) begin
        if (angle_idx == LAST) idx_nxt = WRAP ? '0 : angle_idx;
        else                   idx_nxt = angle_idx + IW'(1);
      end else begin
        if (angle_idx == '0)   idx_nxt = WRAP ? LAST : angle_idx;
        else                   idx_nxt = angle_idx - IW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      angle_idx    <= HOME;
      angle_onehot <= ONE << HOME_IDX;
      at_min       <= (HOME == '0);
      at_max       <= (HOME == LAST);
      moved        <= 1'b0;
      cnt          <= '0;
      dir_up       <= 1'b0;
    end else begin
      angle_idx    <= idx_nxt;
      angle_onehot <= ONE << idx_nxt;
      at_min       <= (idx_nxt == '0);
      at_max       <= (idx_nxt == LAST);
      moved        <= (idx_nxt != angle_idx);
      if (recenter || cnt_clr) cnt <= '0;
      else if (cnt_inc)        cnt <= cnt + CW'(1);
      if (step) dir_up <= step_up;
    end
  end
endmodule

// File: tb/tb_turret_aim_ctrl.sv
// Directed bench for turret_aim_ctrl: saturating default instance plus a WRAP=1 instance.
module tb_turret_aim_ctrl;
  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       frame_tick, recenter;
  logic [3:0] idx, idx_w;
  logic [8:0] oh, oh_w;
  logic       at_min, at_max, moved, at_min_w, at_max_w, moved_w;
  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  turret_aim_ctrl dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_tick(frame_tick), .recenter(recenter),
    .angle_idx(idx), .angle_onehot(oh), .at_min(at_min), .at_max(at_max), .moved(moved));

  turret_aim_ctrl #(.WRAP(1'b1)) dut_w (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_tick(frame_tick), .recenter(recenter),
    .angle_idx(idx_w), .angle_onehot(oh_w), .at_min(at_min_w), .at_max(at_max_w), .moved(moved_w));

  task automatic cyc();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; keycode = 8'h00; frame_tick = 1'b0; recenter = 1'b0;
    cyc(); cyc();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (idx !== 4'd4) begin bad++; $display("FAIL reset_idx got=%0d exp=4", idx); end
    total++; if (oh !== 9'b000010000) begin bad++; $display("FAIL reset_onehot got=%b exp=000010000", oh); end
    total++; if (at_min !== 1'b0 || at_max !== 1'b0) begin bad++; $display("FAIL reset_minmax got=%b%b exp=00", at_min, at_max); end
    total++; if (moved !== 1'b0) begin bad++; $display("FAIL reset_moved got=%b exp=0", moved); end
    total++; if (idx_w !== 4'd4) begin bad++; $display("FAIL reset_idx_w got=%0d exp=4", idx_w); end
  endtask

  task automatic test_hold_no_tick();
    int pulses = 0;
    do_reset();
    keycode = 8'h1A; cyc();
    total++; if (idx !== 4'd5 || moved !== 1'b1) begin bad++; $display("FAIL press_step got idx=%0d moved=%b exp idx=5 moved=1", idx, moved); end
    total++; if (oh !== 9'b000100000) begin bad++; $display("FAIL press_onehot got=%b exp=000100000", oh); end
    for (int i = 0; i < 19; i++) begin cyc(); if (moved) pulses++; end
    total++; if (idx !== 4'd5 || pulses !== 0) begin bad++; $display("FAIL hold_no_tick got idx=%0d pulses=%0d exp idx=5 pulses=0", idx, pulses); end
    keycode = 8'h00; cyc();
  endtask

  task automatic test_auto_repeat();
    int pulses = 0;
    int exp_idx;
    do_reset();
    keycode = 8'h1A; cyc();
    if (moved) pulses++;
    for (int k = 1; k <= 10; k++) begin
      for (int j = 0; j < 3; j++) begin cyc(); if (moved) pulses++; end
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      if (moved) pulses++;
      exp_idx = (k < 3) ? 5 : (k < 5) ? 6 : (k < 7) ? 7 : 8;
      total++; if (idx !== 4'(exp_idx)) begin bad++; $display("FAIL repeat_tick%0d got=%0d exp=%0d", k, idx, exp_idx); end
    end
    cyc(); if (moved) pulses++;
    total++; if (pulses !== 4) begin bad++; $display("FAIL repeat_pulses got=%0d exp=4", pulses); end
    total++; if (at_max !== 1'b1 || oh !== 9'b100000000) begin bad++; $display("FAIL repeat_atmax got max=%b oh=%b exp max=1 oh=100000000", at_max, oh); end
    keycode = 8'h00; cyc();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int t = 0; t < 4; t++) begin
      keycode = 8'h1A; cyc(); keycode = 8'h00; cyc();
    end
    total++; if (idx_w !== 4'd8 || idx !== 4'd8) begin bad++; $display("FAIL taps_to_top got w=%0d s=%0d exp 8/8", idx_w, idx); end
    keycode = 8'h1A; cyc(); keycode = 8'h00;
    total++; if (idx_w !== 4'd0 || at_min_w !== 1'b1 || moved_w !== 1'b1 || oh_w !== 9'b000000001) begin
      bad++; $display("FAIL wrap_up got idx=%0d min=%b moved=%b oh=%b exp 0/1/1/000000001", idx_w, at_min_w, moved_w, oh_w); end
    total++; if (idx !== 4'd8 || moved !== 1'b0 || at_max !== 1'b1) begin
      bad++; $display("FAIL sat_top got idx=%0d moved=%b max=%b exp 8/0/1", idx, moved, at_max); end
    cyc();
    keycode = 8'h16; cyc(); keycode = 8'h00;
    total++; if (idx_w !== 4'd8 || at_max_w !== 1'b1 || moved_w !== 1'b1) begin
      bad++; $display("FAIL wrap_down got idx=%0d max=%b moved=%b exp 8/1/1", idx_w, at_max_w, moved_w); end
    cyc();
  endtask

  task automatic test_dir_change();
    int exp_idx;
    do_reset();
    keycode = 8'h1A; cyc();
    for (int k = 1; k <= 5; k++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
    end
    total++; if (idx !== 4'd7) begin bad++; $display("FAIL dir_pre got=%0d exp=7", idx); end
    keycode = 8'h16; cyc();
    total++; if (idx !== 4'd6 || moved !== 1'b1) begin bad++; $display("FAIL dir_swap got idx=%0d moved=%b exp 6/1", idx, moved); end
    for (int k = 1; k <= 3; k++) begin
      cyc();
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      exp_idx = (k < 3) ? 6 : 5;
      total++; if (idx !== 4'(exp_idx)) begin bad++; $display("FAIL dir_tick%0d got=%0d exp=%0d", k, idx, exp_idx); end
    end
    keycode = 8'h00; cyc();
  endtask

  task automatic test_recenter();
    int pulses = 0;
    do_reset();
    keycode = 8'h1A; cyc();
    for (int k = 1; k <= 5; k++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
    end
    total++; if (idx !== 4'd7) begin bad++; $display("FAIL rc_pre got=%0d exp=7", idx); end
    recenter = 1'b1; frame_tick = 1'b1; cyc(); recenter = 1'b0; frame_tick = 1'b0;
    total++; if (idx !== 4'd4 || moved !== 1'b1 || oh !== 9'b000010000) begin
      bad++; $display("FAIL rc_home got idx=%0d moved=%b oh=%b exp 4/1/000010000", idx, moved, oh); end
    for (int k = 0; k < 12; k++) begin
      frame_tick = (k % 2 == 0); cyc(); if (moved) pulses++;
    end
    frame_tick = 1'b0;
    total++; if (idx !== 4'd4 || pulses !== 0) begin bad++; $display("FAIL lockout got idx=%0d pulses=%0d exp 4/0", idx, pulses); end
    keycode = 8'h00; cyc();
    keycode = 8'h1A; cyc();
    total++; if (idx !== 4'd5 || moved !== 1'b1) begin bad++; $display("FAIL after_lockout got idx=%0d moved=%b exp 5/1", idx, moved); end
    keycode = 8'h00; cyc();
    recenter = 1'b1; cyc(); recenter = 1'b0; cyc();
    recenter = 1'b1; cyc(); recenter = 1'b0;
    total++; if (idx !== 4'd4 || moved !== 1'b0) begin bad++; $display("FAIL rc_nochange got idx=%0d moved=%b exp 4/0", idx, moved); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    keycode = 8'h1A; cyc(); cyc();
    Reset = 1'b1; cyc();
    total++; if (idx !== 4'd4 || moved !== 1'b0) begin bad++; $display("FAIL mid_reset got idx=%0d moved=%b exp 4/0", idx, moved); end
    Reset = 1'b0; cyc();
    total++; if (idx !== 4'd5 || moved !== 1'b1) begin bad++; $display("FAIL repress got idx=%0d moved=%b exp 5/1", idx, moved); end
    keycode = 8'h16; cyc();
    keycode = 8'h16; cyc();
    total++; if (idx !== 4'd4 || at_min !== 1'b0) begin bad++; $display("FAIL quick_swap got idx=%0d min=%b exp 4/0", idx, at_min); end
    keycode = 8'h00; cyc();
  endtask

  initial begin
    test_reset();
    test_hold_no_tick();
    test_auto_repeat();
    test_wrap();
    test_dir_change();
    test_recenter();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
